clock_display_mux: RTL and testbench

//  Downstream display stage for the HH:MM:SS time counter. Takes binary hour/min/sec values,

---
 rtl/clock_display_mux.sv | 149 ++++++++++++++
 tb/tb_clock_display_mux.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_display_mux.sv
// clock_display_mux: snapshots binary HH:MM:SS once per scan frame, converts
// each field to two BCD digits and scans six 7-segment digits with a one-cycle
// blanking gap at every slot change to suppress ghosting.
// Optional build macro: HOUR_LZB_EN blanks the hour tens digit for hours 0..9.
module clock_display_mux #(
    parameter int SCAN_DIV       = 50_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [4:0] inHour,
    input  logic [5:0] inMin,
    input  logic [5:0] inSec,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frameStart
);

    localparam int             PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PCNT_MAX = PW'(SCAN_DIV - 1);
    localparam logic [6:0]     SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [5:0]     AN_OFF   = AN_ACTIVE_LOW ? 6'h3F : 6'h00;
    localparam logic [6:0]     SEG_DASH = 7'h40;

    logic [PW-1:0] pcnt;
    logic [2:0]    idx;
    logic          slotEnd;
    logic          frameEnd;
    logic [4:0]    snapHour;
    logic [5:0]    snapMin;
    logic [5:0]    snapSec;
    logic          frameValid;

    logic [5:0]    fieldVal;
    logic [5:0]    fieldMax;
    logic [2:0]    tens;
    logic [3:0]    ones;
    logic [3:0]    digit;
    logic          inRange;
    logic          blankTens;
    logic [6:0]    segNext;
    logic          dpNext;
    logic [5:0]    anNext;

    // Active-high segment pattern {g,f,e,d,c,b,a} for decimal digits.
    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'd0:    font = 7'h3F;
            4'd1:    font = 7'h06;
            4'd2:    font = 7'h5B;
            4'd3:    font = 7'h4F;
            4'd4:    font = 7'h66;
            4'd5:    font = 7'h6D;
            4'd6:    font = 7'h7D;
            4'd7:    font = 7'h07;
            4'd8:    font = 7'h7F;
            4'd9:    font = 7'h6F;
            default: font = 7'h00;
        endcase
    endfunction

    assign slotEnd  = (pcnt == PCNT_MAX);
    assign frameEnd = slotEnd && (idx == 3'd5);

    // Prescaler and digit-slot index.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pcnt <= '0;
            idx  <= 3'd0;
        end else if (slotEnd) begin
            pcnt <= '0;
            idx  <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Tear-free capture of the time inputs at each frame boundary.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            snapHour   <= '0;
            snapMin    <= '0;
            snapSec    <= '0;
            frameValid <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            frameStart <= frameEnd;
            if (frameEnd) begin
                snapHour   <= inHour;
                snapMin    <= inMin;
                snapSec    <= inSec;
                frameValid <= 1'b1;
            end
        end
    end

    // Pick the field for the current slot and split it into BCD digits.
    always_comb begin
        fieldVal = snapSec;
        fieldMax = 6'd59;
        case (idx)
            3'd2, 3'd3: begin
                fieldVal = snapMin;
                fieldMax = 6'd59;
            end
            3'd4, 3'd5: begin
                fieldVal = {1'b0, snapHour};
                fieldMax = 6'd23;
            end
            default: ;
        endcase
        tens    = 3'(fieldVal / 6'd10);
        ones    = 4'(fieldVal % 6'd10);
        inRange = (fieldVal <= fieldMax);
        digit   = idx[0] ? {1'b0, tens} : ones;
    end

    // Segment, decimal-point and digit-enable values in active-high form.
    always_comb begin
        segNext   = 7'h00;
        dpNext    = 1'b0;
        anNext    = 6'h00;
        blankTens = 1'b0;
`ifdef HOUR_LZB_EN
        blankTens = (idx == 3'd5) && inRange && (fieldVal < 6'd10);
`endif
        if (frameValid && !slotEnd && !blankTens) begin
            segNext = inRange ? font(digit) : SEG_DASH;
            dpNext  = (idx == 3'd2) || (idx == 3'd4);
            anNext  = 6'b000001 << idx;
        end
    end

    // Registered pin drivers with board polarity applied.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            seg <= SEG_OFF;
            dp  <= SEG_ACTIVE_LOW;
            an  <= AN_OFF;
        end else begin
            seg <= segNext ^ {7{SEG_ACTIVE_LOW}};
            dp  <= dpNext ^ SEG_ACTIVE_LOW;
            an  <= anNext ^ {6{AN_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_clock_display_mux.sv
// Testbench for clock_display_mux with SCAN_DIV=4, both polarities active-low.
module tb_clock_display_mux;

    localparam int D     = 4;
    localparam int FRAME = 6 * D;
`ifdef HOUR_LZB_EN
    localparam logic [6:0] HT0 = 7'h7F;
`else
    localparam logic [6:0] HT0 = 7'h40;
`endif

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic [4:0] inHour = 5'd12;
    logic [5:0] inMin = 6'd34;
    logic [5:0] inSec = 6'd56;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frameStart;

    int checks = 0;
    int errors = 0;
    logic monEn = 1'b0;

    clock_display_mux #(
        .SCAN_DIV(D),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .inHour(inHour),
        .inMin(inMin),
        .inSec(inSec),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frameStart(frameStart)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: n = clock edges since reset release; snapshot taken on every
    // edge that completes a whole number of frames.
    int         n = 0;
    int         mH = 0, mM = 0, mS = 0;
    logic [6:0] fontAH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            n  <= 0;
            mH <= 0;
            mM <= 0;
            mS <= 0;
        end else begin
            n <= n + 1;
            if ((n + 1) % FRAME == 0) begin
                mH <= int'(inHour);
                mM <= int'(inMin);
                mS <= int'(inSec);
            end
        end
    end

    // Continuous comparison of all outputs against the model on the falling edge.
    always @(negedge clk) begin : mon
        int p, i, v, lim, d;
        logic [5:0] eAn;
        logic [6:0] eSeg;
        logic eDp, eFs, segChk;
        if (monEn) begin
            eFs = resetN && (n > 0) && (n % FRAME == 0);
            eAn = 6'h3F; eSeg = 7'h7F; eDp = 1'b1; segChk = 1'b1;
            if (resetN && n > FRAME) begin
                p = (n - 1) % D;
                i = ((n - 1) / D) % 6;
                if (p == D - 1) begin
                    segChk = 1'b0;
                end else begin
                    v   = (i < 2) ? mS : (i < 4) ? mM : mH;
                    lim = (i < 4) ? 59 : 23;
                    d   = (i % 2 == 1) ? v / 10 : v % 10;
`ifdef HOUR_LZB_EN
                    if (i == 5 && v < 10) segChk = 1'b0;
`endif
                    if (segChk) begin
                        eAn  = ~(6'b000001 << i);
                        eSeg = (v > lim) ? ~7'h40 : ~fontAH[d];
                        eDp  = !(i == 2 || i == 4);
                    end
                end
            end
            chk("mon_an", 32'(an), 32'(eAn));
            chk("mon_frameStart", 32'(frameStart), 32'(eFs));
            chk("mon_onehot", 32'($countones(~an) <= 1), 32'd1);
            if (segChk) begin
                chk("mon_seg", 32'(seg), 32'(eSeg));
                chk("mon_dp", 32'(dp), 32'(eDp));
            end
        end
    end

    typedef struct {
        logic [4:0]      h;
        logic [5:0]      m;
        logic [5:0]      s;
        logic [5:0][6:0] exp;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] cap [6];

    // Wait for a frame boundary, then record {dp,seg} seen on each digit enable.
    task automatic captureFrame(output int ok, input int chgAt);
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (frameStart) begin ok = 1; break; end
        end
        for (int k = 0; k < 6; k++) cap[k] = 8'hFF;
        if (!ok) begin
            chk("frameStart_timeout", 32'd0, 32'd1);
        end else begin
            for (int c = 0; c < FRAME; c++) begin
                @(negedge clk);
                if (c == chgAt) inSec = 6'd57;
                for (int k = 0; k < 6; k++)
                    if (an == ~(6'b000001 << k)) cap[k] = {dp, seg};
            end
        end
    endtask

    task automatic waitFrameStart(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (frameStart) begin cyc = c; break; end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok, cyc, offCnt;
        vecs[0] = '{5'd12, 6'd34, 6'd56, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
        vecs[1] = '{5'd23, 6'd60, 6'd0,  {7'h24, 7'h30, 7'h3F, 7'h3F, 7'h40, 7'h40}};
        vecs[2] = '{5'd7,  6'd5,  6'd9,  {HT0,   7'h78, 7'h40, 7'h12, 7'h40, 7'h10}};
        vecs[3] = '{5'd23, 6'd59, 6'd59, {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}};
        vecs[4] = '{5'd24, 6'd10, 6'd10, {7'h3F, 7'h3F, 7'h79, 7'h40, 7'h79, 7'h40}};
        vecs[5] = '{5'd5,  6'd61, 6'd62, {HT0,   7'h12, 7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        vecs[6] = '{5'd17, 6'd8,  6'd31, {7'h79, 7'h78, 7'h40, 7'h00, 7'h30, 7'h79}};

        // Reset state and first-frame latency.
        #3 resetN = 1'b0;
        #1;
        monEn = 1'b1;
        chk("rst_an", 32'(an), 32'h3F);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_frameStart", 32'(frameStart), 32'd0);
        repeat (3) @(negedge clk);
        #2 resetN = 1'b1;
        waitFrameStart(cyc);
        chk("first_frame_latency", 32'(cyc), 32'(FRAME));

        // Table-driven frames.
        foreach (vecs[v]) begin
            @(negedge clk);
            inHour = vecs[v].h; inMin = vecs[v].m; inSec = vecs[v].s;
            captureFrame(ok, -1);
            for (int k = 0; k < 6; k++)
                chk($sformatf("vec%0d_digit%0d", v, k), 32'(cap[k]),
                    32'({((k == 2 || k == 4) ? 1'b0 : 1'b1), vecs[v].exp[k]}));
        end

        // Mid-frame input change must not disturb the frame in progress.
        @(negedge clk);
        inHour = 5'd12; inMin = 6'd34; inSec = 6'd56;
        captureFrame(ok, -1);
        captureFrame(ok, 8);
        chk("midframe_hold_sec", 32'(cap[0][6:0]), 32'h02);
        captureFrame(ok, -1);
        chk("nextframe_sec", 32'(cap[0][6:0]), 32'h78);

        // Blank slots: one per slot, 12 over two frames.
        inSec = 6'd56;
        waitFrameStart(cyc);
        chk("blank_wait", 32'(cyc > 0), 32'd1);
        offCnt = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            if (an == 6'h3F) offCnt++;
        end
        chk("blank_count", 32'(offCnt), 32'd12);

        // Asynchronous reset in the middle of idx 3, then restart latency.
        waitFrameStart(cyc);
        repeat (3 * D + 1) @(posedge clk);
        #3 resetN = 1'b0;
        #1;
        chk("async_rst_an", 32'(an), 32'h3F);
        chk("async_rst_seg", 32'(seg), 32'h7F);
        chk("async_rst_dp", 32'(dp), 32'd1);
        @(negedge clk);
        #2 resetN = 1'b1;
        waitFrameStart(cyc);
        chk("restart_latency", 32'(cyc), 32'(FRAME));

        // Randomized inputs, mostly in range, changing at arbitrary times.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    inHour = 5'($urandom_range(0, 23));
                    inMin  = 6'($urandom_range(0, 59));
                    inSec  = 6'($urandom_range(0, 59));
                end else begin
                    inHour = 5'($urandom_range(0, 31));
                    inMin  = 6'($urandom_range(0, 63));
                    inSec  = 6'($urandom_range(0, 63));
                end
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
